// File: rtl/tv_sequencer_pkg.sv
// Shared types for the test-vector sequencer: run-state encoding and the
// width helper used to size index/count fields.
package tv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tv_state_e;

    // Index and count fields must hold the value DEPTH itself (clamped N, error count).
    function automatic int idx_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tv_sequencer_if.sv
// Bus between the sequencer and its controller / device under test.
// Handshake: load_en and start are single-cycle requests sampled on the rising
// clock edge; no ready is returned, so a request made while busy is simply dropped.
interface tv_sequencer_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 2,
    parameter int IDX_W = 4
);
    import tv_seq_pkg::*;

    logic             load_en;
    logic [IDX_W-1:0] load_addr;
    logic [IN_W-1:0]  load_stim;
    logic [OUT_W-1:0] load_exp;
    logic [IDX_W-1:0] num_vecs;
    logic             start;
    logic             abort;
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] dut_resp;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] vec_idx;
    logic [IDX_W-1:0] err_cnt;
    logic             first_err_valid;
    logic [IDX_W-1:0] first_err_idx;
    tv_state_e        state_dbg;

    modport master (
        output load_en, load_addr, load_stim, load_exp, num_vecs, start, abort, dut_resp,
        input  stim, busy, done, vec_idx, err_cnt, first_err_valid, first_err_idx, state_dbg
    );

    modport slave (
        input  load_en, load_addr, load_stim, load_exp, num_vecs, start, abort, dut_resp,
        output stim, busy, done, vec_idx, err_cnt, first_err_valid, first_err_idx, state_dbg
    );

endinterface

// File: rtl/tv_sequencer_mem.sv
// Vector store: DEPTH entries of {stim, exp}, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module tv_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 6,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [W-1:0]     rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < DEPTH_I)) begin
            mem_q[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    // Reads past the last entry return zero so look-ahead at the end of a run is harmless.
    assign rd_data = (rd_addr < DEPTH_I) ? mem_q[rd_addr[AW-1:0]] : '0;

endmodule

// File: rtl/tv_sequencer.sv
// Test-vector sequencer: applies stored stimuli for GAP cycles each, compares
// the DUT response at the end of every hold and records mismatch statistics.
module tv_sequencer
    import tv_seq_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int OUT_W = 2,
    parameter int DEPTH = 8,
    parameter int GAP   = 10,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input logic           clk,
    input logic           rst_n,
    tv_sequencer_if.slave bus
);
    localparam int CNT_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] DEPTH_I  = IDX_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GAP - 1);

    tv_state_e        state_q, state_d;
    logic [IN_W-1:0]  stim_q, stim_d;
    logic [OUT_W-1:0] exp_q, exp_d;
    logic [IDX_W-1:0] vec_idx_q, vec_idx_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] err_cnt_q, err_cnt_d;
    logic             fev_q, fev_d;
    logic [IDX_W-1:0] fei_q, fei_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [IDX_W-1:0]      rd_addr;
    logic [IN_W+OUT_W-1:0] rd_data;
    logic [IN_W-1:0]       rd_stim;
    logic [OUT_W-1:0]      rd_exp;
    logic [IDX_W-1:0]      n_clamped;
    logic                  load_ok;

    // The read port looks one entry ahead so stim and its expected value load together.
    assign rd_addr   = (state_q == ST_RUN) ? vec_idx_q + IDX_W'(1) : '0;
    assign rd_stim   = rd_data[IN_W+OUT_W-1:OUT_W];
    assign rd_exp    = rd_data[OUT_W-1:0];
    assign n_clamped = (bus.num_vecs > DEPTH_I) ? DEPTH_I : bus.num_vecs;
    assign load_ok   = bus.load_en && !bus.start && (state_q != ST_RUN);

    tv_mem #(
        .DEPTH (DEPTH),
        .W     (IN_W + OUT_W),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (load_ok),
        .wr_addr (bus.load_addr),
        .wr_data ({bus.load_stim, bus.load_exp}),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        stim_d    = stim_q;
        exp_d     = exp_q;
        vec_idx_d = vec_idx_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        fev_d     = fev_q;
        fei_d     = fei_q;
        busy_d    = busy_q;
        done_d    = done_q;
        if (bus.abort) begin
            // Results stay visible; a compare due on this edge is dropped.
            state_d = ST_IDLE;
            stim_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        err_cnt_d = '0;
                        fev_d     = 1'b0;
                        fei_d     = '0;
                        vec_idx_d = '0;
                        cnt_d     = '0;
                        n_d       = n_clamped;
                        if (n_clamped == '0) begin
                            state_d = ST_DONE;
                            stim_d  = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                            stim_d  = rd_stim;
                            exp_d   = rd_exp;
                            busy_d  = 1'b1;
                            done_d  = 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = '0;
                        if (bus.dut_resp != exp_q) begin
                            err_cnt_d = err_cnt_q + IDX_W'(1);
                            if (!fev_q) begin
                                fev_d = 1'b1;
                                fei_d = vec_idx_q;
                            end
                        end
                        if (vec_idx_q < n_q - IDX_W'(1)) begin
                            vec_idx_d = vec_idx_q + IDX_W'(1);
                            stim_d    = rd_stim;
                            exp_d     = rd_exp;
                        end else begin
                            state_d = ST_DONE;
                            stim_d  = '0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    stim_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            stim_q    <= '0;
            exp_q     <= '0;
            vec_idx_q <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
            fev_q     <= 1'b0;
            fei_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            stim_q    <= stim_d;
            exp_q     <= exp_d;
            vec_idx_q <= vec_idx_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
            fev_q     <= fev_d;
            fei_q     <= fei_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.stim            = stim_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.vec_idx         = vec_idx_q;
    assign bus.err_cnt         = err_cnt_q;
    assign bus.first_err_valid = fev_q;
    assign bus.first_err_idx   = fei_q;
    assign bus.state_dbg       = state_q;

endmodule

// File: doc/tv_sequencer.md
# tv_sequencer

Parametrised, synthesisable test-vector sequencer and checker for the lab's combinational circuits. It holds up to DEPTH stimulus/expected-response pairs and applies them one by one to a device under test (DUT), holding each for GAP cycles. At the end of each hold it compares the DUT response against the expected value and keeps a mismatch count and the index of the first failure. This replaces fixed-delay, unchecked stimulus loops with a reusable on-chip block that checks its own results.

## Interface
- IN_W, 4: stimulus width driven to the DUT
- OUT_W, 2: DUT response / expected-value width
- DEPTH, 8: vector memory entries (≥1)
- GAP, 10: cycles each vector is held (≥1)
- IDX_W, $clog2(DEPTH+1): width of index and count fields
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load_en  in  1  write one vector entry this cycle
- load_addr  in  IDX_W  entry written (≥DEPTH ignored)
- load_stim  in  IN_W  stimulus field written
- load_exp  in  OUT_W  expected-response field written
- num_vecs  in  IDX_W  vectors to run, sampled at start (clamped to DEPTH)
- start  in  1  begin a run (IDLE or DONE only)
- abort  in  1  stop a run, return to IDLE
- stim  out  IN_W  registered drive to the DUT
- dut_resp  in  OUT_W  DUT output
- busy  out  1  run in progress
- done  out  1  run finished (level, held in DONE)
- vec_idx  out  IDX_W  index of the vector currently applied
- err_cnt  out  IDX_W  mismatches in the current/last run
- first_err_valid  out  1  at least one mismatch recorded
- first_err_idx  out  IDX_W  index of the first mismatch

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state IDLE, stim 0, busy 0, done 0, vec_idx 0, err_cnt 0, first_err_valid 0, first_err_idx 0. Memory contents are not reset.
- Load: accepted only in IDLE/DONE with start low. Load requests in RUN, or with start high, are ignored. A write is visible to a run started on a later cycle.
- IDLE/DONE + start: clear err_cnt, first_err_*, and done. Latch N = min(num_vecs, DEPTH).
  - If N==0: go to DONE with no vectors applied.
  - Otherwise: go to RUN with vec_idx=0 and stim=mem_stim[0], in the same edge.
- RUN: a hold counter counts GAP cycles. On the GAP-th edge after stim changed, dut_resp is compared with mem_exp[vec_idx].
  - On mismatch: err_cnt+1. If first_err_valid==0, set first_err_valid=1 and first_err_idx=vec_idx.
  - If vec_idx<N-1: on that same edge, vec_idx+1 and stim=mem_stim[vec_idx+1].
  - Otherwise: go to DONE, stim=0, and vec_idx holds the last index.
- DONE: done=1 and busy=0. Results are held until the next start.
- abort (any state, priority over start): go to IDLE, stim=0, done=0. Results are held. If abort arrives on a compare edge, that compare is discarded.
- Comparison is full-width equality. err_cnt cannot overflow because IDX_W covers DEPTH.

## Timing
- start sampled at edge E0. stim=vector k is valid from E0+k·GAP through E0+(k+1)·GAP.
- dut_resp for vector k is sampled at edge E0+(k+1)·GAP. The DUT therefore has GAP cycles of settling time and must be combinational or have latency <GAP.
- done and busy=0 are visible after edge E0+N·GAP. Total run length is N·GAP cycles.
- busy=1 exactly while the state is RUN.
- Asynchronous rst_n mid-run forces all reset values immediately, with no pending compare.

## Structure
- Package tv_seq_pkg holds the state enum (IDLE, RUN, DONE) and the clog2-based width helper.
- Sub-module tv_mem: DEPTH×(IN_W+OUT_W) register file with one synchronous write port and one asynchronous read port, indexed by vec_idx.
- Top level holds the FSM, hold counter, comparator, and result registers.

## Test plan
The bench uses IN_W=3, OUT_W=2, GAP=10, and a full-adder DUT model where stim = {a,b,cin} and dut_resp = {cout,sum}.
- Load 3'b000/2'b00, 3'b011/2'b10, 3'b111/2'b11. Start with num_vecs=3 → done after 30 cycles, err_cnt=0, first_err_valid=0.
- Load entry 1 expected as 2'b01 (wrong) → err_cnt=1, first_err_idx=1. stim sequence is 0, 3, 7, then 0 after done.
- num_vecs=0 → done asserts one cycle after start, stim stays 0, busy never asserts.
- Assert abort at cycle 15 of a 3-vector run → IDLE, done=0, stim=0, err_cnt reflects only vector 0. A second start reruns cleanly.
- load_en pulses during RUN → memory unchanged and rerun results identical. num_vecs=15 with DEPTH=8 → exactly 8 vectors applied, done at 80 cycles.
- rst_n low mid-run at cycle 12 → all outputs return to reset values asynchronously. After release, start runs normally.
